// File: rtl/polar64_decode_scheduler_if.sv
// Requester, decoder and response signals of the polar64 decode scheduler.
// The master modport is the scheduler's view; slave is the environment's view.
interface polar64_decode_scheduler_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*64-1:0] req_rx;
    logic [NREQ-1:0]    req_ready;

    logic               dec_start;
    logic [63:0]        dec_rx;
    logic               dec_done;
    logic [23:0]        dec_data;
    logic               dec_valid;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [23:0]        rsp_data;
    logic               rsp_ok;
    logic               rsp_timeout;

    modport master (
        input  req_valid, req_rx, dec_done, dec_data, dec_valid, rsp_ready,
        output req_ready, dec_start, dec_rx,
        output rsp_valid, rsp_id, rsp_data, rsp_ok, rsp_timeout
    );

    modport slave (
        output req_valid, req_rx, dec_done, dec_data, dec_valid, rsp_ready,
        input  req_ready, dec_start, dec_rx,
        input  rsp_valid, rsp_id, rsp_data, rsp_ok, rsp_timeout
    );
endinterface

// File: rtl/polar64_decode_scheduler.sv
// Round-robin scheduler sharing one polar64 CRC16 decoder among NREQ requesters,
// with a watchdog on the decoder. Define POLAR_SCHED_STATS_EN for job/fail/timeout counters.
//
// state | meaning
// IDLE  | arbitrate requesters, accept one job
// ISSUE | pulse dec_start for one cycle, arm watchdog
// WAIT  | wait for dec_done or watchdog expiry
// RESP  | hold tagged result until rsp_ready
module polar64_decode_scheduler #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    polar64_decode_scheduler_if.master bus,
`ifdef POLAR_SCHED_STATS_EN
    output logic [15:0]                stat_jobs,
    output logic [15:0]                stat_fail,
    output logic [15:0]                stat_tmo,
`endif
    output logic                       busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    // one spare count so the watchdog never wraps on the cycle it leaves WAIT
    localparam int             WDW     = $clog2(TIMEOUT + 2);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT);
    localparam logic [IDW:0]   NREQ_W  = (IDW + 1)'(NREQ);
    localparam logic [IDW-1:0] ID_LAST = IDW'(NREQ - 1);

    logic [1:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] job_id;
    logic [WDW-1:0] wd_cnt;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW:0]   scan_sum;
    logic [IDW-1:0] scan_idx;
    logic [63:0]    rx_word [NREQ];

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            rx_word[k] = bus.req_rx[64*k +: 64];
        end
    end

    // first requesting index at or after rr_ptr, wrapping modulo NREQ
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (IDW + 1)'(k);
            if (scan_sum >= NREQ_W) begin
                scan_sum = scan_sum - NREQ_W;
            end
            scan_idx = scan_sum[IDW-1:0];
            if (!grant_found && bus.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && grant_found && !rst) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    assign bus.dec_start = (state == ISSUE);
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            job_id          <= '0;
            wd_cnt          <= '0;
            bus.dec_rx      <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_id      <= '0;
            bus.rsp_data    <= '0;
            bus.rsp_ok      <= 1'b0;
            bus.rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        bus.dec_rx <= rx_word[grant_idx];
                        job_id     <= grant_idx;
                        rr_ptr     <= (grant_idx == ID_LAST) ? '0 : grant_idx + IDW'(1);
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd_cnt <= WDW'(1);
                    state  <= WAIT;
                end
                WAIT: begin
                    wd_cnt <= wd_cnt + WDW'(1);
                    // a completion in the expiry cycle still wins over the watchdog
                    if (bus.dec_done) begin
                        bus.rsp_data    <= bus.dec_valid ? bus.dec_data : 24'd0;
                        bus.rsp_ok      <= bus.dec_valid;
                        bus.rsp_timeout <= 1'b0;
                        bus.rsp_id      <= job_id;
                        bus.rsp_valid   <= 1'b1;
                        state           <= RESP;
                    end else if (wd_cnt == WD_LAST) begin
                        bus.rsp_data    <= 24'd0;
                        bus.rsp_ok      <= 1'b0;
                        bus.rsp_timeout <= 1'b1;
                        bus.rsp_id      <= job_id;
                        bus.rsp_valid   <= 1'b1;
                        state           <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef POLAR_SCHED_STATS_EN
    logic rsp_fire;
    assign rsp_fire = bus.rsp_valid & bus.rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_jobs <= 16'd0;
            stat_fail <= 16'd0;
            stat_tmo  <= 16'd0;
        end else if (rsp_fire) begin
            if (stat_jobs != 16'hFFFF) begin
                stat_jobs <= stat_jobs + 16'd1;
            end
            if (!bus.rsp_ok && !bus.rsp_timeout && stat_fail != 16'hFFFF) begin
                stat_fail <= stat_fail + 16'd1;
            end
            if (bus.rsp_timeout && stat_tmo != 16'hFFFF) begin
                stat_tmo <= stat_tmo + 16'd1;
            end
        end
    end
`endif

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.req_ready));

    a_rsp_hold: assert property (@(posedge clk) disable iff (rst)
        (bus.rsp_valid && !bus.rsp_ready) |=> (bus.rsp_valid && $stable(bus.rsp_data)
                                               && $stable(bus.rsp_id)));

endmodule
